// File: rtl/bus_arbiter_mux_if.sv
// Source-side strobes/data and registered bus-side results of the datapath bus driver.
// The master modport drives requests; the slave modport is the arbiter itself.
interface bus_arbiter_mux_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 24,
  parameter int IDX_W   = $clog2(NUM_SRC)
);
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_req;
  logic                     lock;
  logic                     conflict_clr;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic [NUM_SRC-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     conflict;
  logic                     conflict_sticky;

  modport master (
    output src_data, src_req, lock, conflict_clr,
    input  bus_out, bus_valid, grant, grant_idx, conflict, conflict_sticky
  );

  modport slave (
    input  src_data, src_req, lock, conflict_clr,
    output bus_out, bus_valid, grant, grant_idx, conflict, conflict_sticky
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered datapath bus driver: fixed-priority or round-robin arbitration over one-hot
// drive strobes, multi-cycle owner lock, and multi-driver conflict flagging.
module bus_arbiter_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 24,
  parameter int MODE    = 0
) (
  input  logic               clock,
  input  logic               clear,
  bus_arbiter_mux_if.slave   bus
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {ARB, HELD} state_e;

  state_e                       state_q;
  logic [IDX_W-1:0]             rr_ptr_q;
  logic [WIDTH-1:0]             bus_out_q;
  logic                         bus_valid_q;
  logic [NUM_SRC-1:0]           grant_q;
  logic [IDX_W-1:0]             grant_idx_q;
  logic                         conflict_q;
  logic                         sticky_q;

  logic [NUM_SRC-1:0][WIDTH-1:0] src_arr;
  logic [IDX_W-1:0]             win_d;
  logic                         win_vld_d;
  logic                         hold_d;
  logic                         conflict_d;
  logic                         sticky_d;
  logic [NUM_SRC-1:0]           grant_d;

  assign src_arr = bus.src_data;

  // Walk candidates from the far end toward the preferred one so the last hit wins.
  always_comb begin
    int j;
    win_d     = '0;
    win_vld_d = 1'b0;
    j         = 0;
    if (MODE == 0) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (bus.src_req[i]) begin
          win_d     = IDX_W'(i);
          win_vld_d = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_SRC) j = j - NUM_SRC;
        if (bus.src_req[j]) begin
          win_d     = IDX_W'(j);
          win_vld_d = 1'b1;
        end
      end
    end
  end

  // Holding masks every other requester, so conflicts are only judged while arbitrating.
  assign hold_d     = (state_q == HELD) && bus.lock && bus.src_req[grant_idx_q];
  assign conflict_d = !hold_d && ($countones(bus.src_req) > 1);
  assign sticky_d   = conflict_d | (sticky_q & ~bus.conflict_clr);
  assign grant_d    = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_d;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= ARB;
      rr_ptr_q    <= IDX_W'(NUM_SRC - 1);
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      conflict_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      if (hold_d) begin
        bus_out_q   <= src_arr[grant_idx_q];
        bus_valid_q <= 1'b1;
      end else if (win_vld_d) begin
        bus_out_q   <= src_arr[win_d];
        bus_valid_q <= 1'b1;
        grant_q     <= grant_d;
        grant_idx_q <= win_d;
        if (MODE == 1) rr_ptr_q <= win_d;
        state_q     <= bus.lock ? HELD : ARB;
      end else begin
        bus_valid_q <= 1'b0;
        grant_q     <= '0;
        state_q     <= ARB;
      end
    end
  end

  assign bus.bus_out         = bus_out_q;
  assign bus.bus_valid       = bus_valid_q;
  assign bus.grant           = grant_q;
  assign bus.grant_idx       = grant_idx_q;
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: a fixed-priority and a round-robin instance share clock and reset.
module tb_bus_arbiter_mux;
  localparam int W = 32;
  localparam int N = 24;

  logic clock;
  logic clear;
  int   total;
  int   bad;

  bus_arbiter_mux_if #(.WIDTH(W), .NUM_SRC(N)) if0 ();
  bus_arbiter_mux_if #(.WIDTH(W), .NUM_SRC(N)) if1 ();

  bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(0)) u_fix (
    .clock (clock),
    .clear (clear),
    .bus   (if0)
  );

  bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(1)) u_rr (
    .clock (clock),
    .clear (clear),
    .bus   (if1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear = 1'b0;
    if0.src_data = '0; if0.src_req = '0; if0.lock = 1'b0; if0.conflict_clr = 1'b0;
    if1.src_data = '0; if1.src_req = '0; if1.lock = 1'b0; if1.conflict_clr = 1'b0;
    tick();
    tick();
    chk("rst_bus",    if0.bus_out, 32'd0);
    chk("rst_valid",  {31'd0, if0.bus_valid}, 32'd0);
    chk("rst_grant",  {8'd0, if0.grant}, 32'd0);
    chk("rst_idx",    {27'd0, if0.grant_idx}, 32'd0);
    chk("rst_cfl",    {31'd0, if0.conflict}, 32'd0);
    chk("rst_sticky", {31'd0, if0.conflict_sticky}, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    // single requesters
    if0.src_data[0*W +: W] = 32'd0;
    if0.src_req = 24'h000001;
    tick();
    chk("t1_bus0",   if0.bus_out, 32'd0);
    chk("t1_idx0",   {27'd0, if0.grant_idx}, 32'd0);
    chk("t1_valid0", {31'd0, if0.bus_valid}, 32'd1);
    if0.src_data[3*W +: W] = 32'd230;
    if0.src_req = 24'h000008;
    tick();
    chk("t1_bus3",   if0.bus_out, 32'd230);
    chk("t1_grant3", {8'd0, if0.grant}, 32'h000008);

    // idle keeps data, drops valid and grant
    if0.src_req = '0;
    tick();
    chk("idle_bus",   if0.bus_out, 32'd230);
    chk("idle_valid", {31'd0, if0.bus_valid}, 32'd0);
    chk("idle_grant", {8'd0, if0.grant}, 32'd0);
    chk("idle_idx",   {27'd0, if0.grant_idx}, 32'd3);

    // fixed priority with conflict
    if0.src_data[5*W +: W] = 32'd55;
    if0.src_data[2*W +: W] = 32'd22;
    if0.src_req = 24'h000024;
    tick();
    chk("t2_bus",    if0.bus_out, 32'd22);
    chk("t2_idx",    {27'd0, if0.grant_idx}, 32'd2);
    chk("t2_cfl",    {31'd0, if0.conflict}, 32'd1);
    chk("t2_sticky", {31'd0, if0.conflict_sticky}, 32'd1);
    if0.src_req = '0;
    tick();
    chk("t2_cfl_pulse", {31'd0, if0.conflict}, 32'd0);
    chk("t2_sticky_hold", {31'd0, if0.conflict_sticky}, 32'd1);
    if0.conflict_clr = 1'b1;
    tick();
    chk("t2_sticky_clr", {31'd0, if0.conflict_sticky}, 32'd0);
    if0.src_req = 24'h000024;
    tick();
    chk("t2_set_wins", {31'd0, if0.conflict_sticky}, 32'd1);
    chk("t2_cfl2",     {31'd0, if0.conflict}, 32'd1);
    if0.conflict_clr = 1'b0;
    if0.src_req = '0;
    tick();

    // lock holds owner and tracks its data
    if0.src_data[4*W +: W] = 32'h44;
    if0.src_data[9*W +: W] = 32'h99;
    if0.src_req = 24'h000010;
    if0.lock = 1'b1;
    tick();
    chk("t4_idx_lock", {27'd0, if0.grant_idx}, 32'd4);
    if0.src_req = 24'h000210;
    if0.src_data[4*W +: W] = 32'hDEAD;
    tick();
    chk("t4_bus_track", if0.bus_out, 32'hDEAD);
    chk("t4_idx_held",  {27'd0, if0.grant_idx}, 32'd4);
    chk("t4_no_cfl",    {31'd0, if0.conflict}, 32'd0);
    chk("t4_grant",     {8'd0, if0.grant}, 32'h000010);
    if0.lock = 1'b0;
    if0.src_req = 24'h000200;
    tick();
    chk("t4_idx_rel", {27'd0, if0.grant_idx}, 32'd9);
    chk("t4_bus_rel", if0.bus_out, 32'h99);
    if0.src_req = '0;

    // round-robin
    if1.src_data[0*W +: W]  = 32'h100;
    if1.src_data[7*W +: W]  = 32'h700;
    if1.src_data[23*W +: W] = 32'h2300;
    if1.src_req = 24'h800000;
    tick();
    chk("t3_single23", {27'd0, if1.grant_idx}, 32'd23);
    if1.src_req = 24'h800081;
    tick();
    chk("t3_rr0", {27'd0, if1.grant_idx}, 32'd0);
    chk("t3_bus0", if1.bus_out, 32'h100);
    tick();
    chk("t3_rr7", {27'd0, if1.grant_idx}, 32'd7);
    tick();
    chk("t3_rr23", {27'd0, if1.grant_idx}, 32'd23);
    chk("t3_bus23", if1.bus_out, 32'h2300);
    tick();
    chk("t3_rr_wrap", {27'd0, if1.grant_idx}, 32'd0);

    // reset mid-lock
    if1.lock = 1'b1;
    tick();
    chk("t6_lock7", {27'd0, if1.grant_idx}, 32'd7);
    #2;
    clear = 1'b0;
    #1;
    chk("t6_bus",    if1.bus_out, 32'd0);
    chk("t6_valid",  {31'd0, if1.bus_valid}, 32'd0);
    chk("t6_grant",  {8'd0, if1.grant}, 32'd0);
    chk("t6_idx",    {27'd0, if1.grant_idx}, 32'd0);
    chk("t6_sticky", {31'd0, if1.conflict_sticky}, 32'd0);
    if1.lock = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    tick();
    chk("t6_first_rr", {27'd0, if1.grant_idx}, 32'd0);
    chk("t6_first_bus", if1.bus_out, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
